// File: rtl/param_seq_detect.sv
// Serial bit-pattern detector with run-time pattern/mask, overlap mode and a
// saturating match counter. Match is registered one cycle after the completing bit.
module param_seq_detect #(
  parameter int unsigned      PAT_W           = 8,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [PAT_W-1:0] DEFAULT_PATTERN = PAT_W'(8'b10010110),
  parameter logic [PAT_W-1:0] DEFAULT_MASK    = {PAT_W{1'b1}},
  parameter logic             DEFAULT_OVERLAP = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             count_clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic              overlap_q, overlap_d;
  logic              armed_q, armed_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hit;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    fill_inc  = fill_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    hit       = 1'b0;

    if (cfg_load) begin
      // Loading config discards any concurrent bit and restarts the window.
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      fill_inc  = '0;
    end else if (in_valid) begin
      hist_d   = {hist_q[PAT_W-2:0], in_bit};
      fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
      hit      = (fill_inc == FILL_FULL) && (((hist_d ^ pattern_q) & mask_q) == '0);
      fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
    end

    // armed reflects fill before a non-overlap clear, so it drops one cycle later.
    armed_d = (fill_inc == FILL_FULL);
    match_d = hit;

    count_d = count_q;
    if (count_clear) begin
      count_d = '0;
    end else if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEFAULT_PATTERN;
      mask_q    <= DEFAULT_MASK;
      overlap_q <= DEFAULT_OVERLAP;
      armed_q   <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      armed_q   <= armed_d;
      match_q   <= match_d;
      count_q   <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed bench for param_seq_detect: a default-width instance plus a 2-bit counter
// instance sharing the same stimulus.
module tb_param_seq_detect;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        in_valid, in_bit, cfg_load, cfg_overlap, count_clear;
  logic [7:0]  cfg_pattern, cfg_mask;
  logic        match, armed, match2, armed2;
  logic [15:0] match_count;
  logic [1:0]  match_count2;

  int n_tests = 0;
  int n_fail  = 0;

  param_seq_detect #(.PAT_W(8), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .count_clear(count_clear),
    .match(match), .match_count(match_count), .armed(armed)
  );

  param_seq_detect #(.PAT_W(8), .CNT_W(2)) dut_sat (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .count_clear(count_clear),
    .match(match2), .match_count(match_count2), .armed(armed2)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the current controls; sample #1 after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    count_clear = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [7:0] m, input logic ov);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_mask    = m;
    cfg_overlap = ov;
    tick();
  endtask

  task automatic clear_count();
    count_clear = 1'b1;
    tick();
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  // Feed n bits MSB-first; mv[i] / av[i] = match / armed seen after bit i.
  task automatic feed(input logic [31:0] bits, input int n,
                      output logic [31:0] mv, output logic [31:0] av);
    mv = '0;
    av = '0;
    for (int i = 0; i < n; i++) begin
      send(bits[n-1-i]);
      mv[i] = match;
      av[i] = armed;
    end
  endtask

  logic [31:0] mv, av;
  int          idle_pulses;
  logic [7:0]  seq1;

  initial begin
    Reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_overlap = 1'b0; count_clear = 1'b0; cfg_pattern = '0; cfg_mask = '0;
    seq1 = 8'b1001_0110;

    do_reset();
    check("reset_match", 32'(match), 32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    check("reset_armed", 32'(armed), 32'd0);

    // 1: default pattern
    feed(32'(seq1), 8, mv, av);
    check("t1_match_vec", mv, 32'h80);
    check("t1_count", 32'(match_count), 32'd1);
    check("t1_armed", 32'(armed), 32'd1);
    tick();
    check("t1_pulse_one_cycle", 32'(match), 32'd0);

    // 2: all-ones, overlapping
    load_cfg(8'hFF, 8'hFF, 1'b1);
    check("t2_armed_after_load", 32'(armed), 32'd0);
    check("t2_count_kept_by_load", 32'(match_count), 32'd1);
    clear_count();
    check("t2_count_cleared", 32'(match_count), 32'd0);
    feed(32'h3FF, 10, mv, av);
    check("t2_match_vec", mv, 32'h380);
    check("t2_count", 32'(match_count), 32'd3);

    // 3: all-ones, non-overlapping
    load_cfg(8'hFF, 8'hFF, 1'b0);
    clear_count();
    feed(32'h3FF, 10, mv, av);
    check("t3_match_vec", mv, 32'h080);
    check("t3_armed_vec", av, 32'h080);
    check("t3_count", 32'(match_count), 32'd1);

    // 4: masked compare
    load_cfg(8'hA5, 8'hF0, 1'b1);
    clear_count();
    feed(32'hA3, 8, mv, av);
    check("t4_masked_hit", mv, 32'h80);
    load_cfg(8'hA5, 8'hF0, 1'b1);
    feed(32'hB0, 8, mv, av);
    check("t4_masked_miss", mv, 32'h00);
    check("t4_count", 32'(match_count), 32'd1);

    // 5: idle gaps between valid bits
    load_cfg(8'b1001_0110, 8'hFF, 1'b1);
    clear_count();
    mv = '0;
    idle_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send(seq1[7-i]);
      mv[i] = match;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (match) idle_pulses++;
      end
    end
    check("t5_match_vec", mv, 32'h80);
    check("t5_idle_pulses", 32'(idle_pulses), 32'd0);
    check("t5_count", 32'(match_count), 32'd1);

    // 6a: cfg_load on the completing bit discards it
    load_cfg(8'b1001_0110, 8'hFF, 1'b1);
    feed(32'b100_1011, 7, mv, av);
    cfg_load = 1'b1; cfg_pattern = 8'b1001_0110; cfg_mask = 8'hFF; cfg_overlap = 1'b1;
    send(1'b0);
    check("t6_load_no_match", 32'(match), 32'd0);
    check("t6_load_count_held", 32'(match_count), 32'd1);
    check("t6_load_armed", 32'(armed), 32'd0);
    feed(32'b001, 3, mv, av);
    check("t6_load_no_late_match", mv, 32'h0);

    // 6b: count_clear beats a simultaneous increment
    load_cfg(8'b1001_0110, 8'hFF, 1'b1);
    feed(32'b100_1011, 7, mv, av);
    count_clear = 1'b1;
    send(1'b0);
    check("t6_clear_match", 32'(match), 32'd1);
    check("t6_clear_count", 32'(match_count), 32'd0);

    // 6c: saturation of a 2-bit counter
    load_cfg(8'hFF, 8'hFF, 1'b1);
    clear_count();
    feed(32'hFFF, 12, mv, av);
    check("t6_sat_match_vec", mv, 32'hF80);
    check("t6_sat_count2", 32'(match_count2), 32'd3);
    check("t6_sat_count16", 32'(match_count), 32'd5);

    // Reset mid-stream loses partial history and restores the default pattern
    do_reset();
    check("rst_count", 32'(match_count), 32'd0);
    feed(32'b10010, 5, mv, av);
    do_reset();
    feed(32'b110_1001_0110, 11, mv, av);
    check("rst_straddle_vec", mv, 32'h400);
    check("rst_count_after", 32'(match_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
